alu_rr_arbiter: RTL and testbench

//   Shares one W-bit ALU between two requesters using round-robin arbitration.

---
 rtl/alu_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_rr_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// Round-robin share of one W-bit ALU between two valid/ready requesters; result registered (1-cycle latency), tagged with id.
// Grants only when the result slot is free or draining this cycle; ALU_ARB_STATS_EN adds saturating per-requester grant counters.
module alu_rr_arbiter #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*W-1:0]     req_a,
  input  logic [2*W-1:0]     req_b,
  input  logic [5:0]         req_op,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [W-1:0]       rsp_f,
  output logic               rsp_zero,
  output logic               rsp_over,
  output logic               rsp_cout,
  output logic [2*CNT_W-1:0] gnt_cnt
);

  typedef struct packed {
    logic [W-1:0] f;
    logic         zero;
    logic         over;
    logic         cout;
  } res_t;

  logic         last_gnt;
  logic         free;
  logic         sel;
  logic [W-1:0] a, b;
  logic [2:0]   op;
  logic [W:0]   sum, diff;
  logic         add_over, sub_over, less;
  res_t         alu, rsp_q;

  assign free = !rsp_valid || rsp_ready;
  assign sel  = (req_valid == 2'b11) ? !last_gnt : req_valid[1];

  // Gated by rst so that no handshake can complete in a reset cycle.
  always_comb begin
    req_ready = 2'b00;
    if (free && (|req_valid) && !rst)
      req_ready = sel ? 2'b10 : 2'b01;
  end

  assign a  = sel ? req_a[2*W-1:W] : req_a[W-1:0];
  assign b  = sel ? req_b[2*W-1:W] : req_b[W-1:0];
  assign op = sel ? req_op[5:3]    : req_op[2:0];

  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff     = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
  assign add_over = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
  assign sub_over = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
  // Signed a<b is the sign of a-b corrected by overflow.
  assign less     = diff[W-1] ^ sub_over;

  always_comb begin
    alu = '0;
    case (op)
      3'b000: begin
        alu.f    = sum[W-1:0];
        alu.cout = sum[W];
        alu.over = add_over;
      end
      3'b001: begin
        alu.f    = diff[W-1:0];
        alu.cout = diff[W];
        alu.over = sub_over;
      end
      3'b011:  alu.f = a & b;
      3'b100:  alu.f = a | b;
      3'b101:  alu.f = a ^ b;
      3'b110:  alu.f = {{(W-1){1'b0}}, less};
      3'b111:  alu.f = {{(W-1){1'b0}}, a == b};
      default: alu.f = '0;
    endcase
    // Compares report flags of a-b; the reserved opcode reports none.
    if (op == 3'b110 || op == 3'b111) begin
      alu.cout = diff[W];
      alu.over = sub_over;
      alu.zero = (diff[W-1:0] == '0);
    end else if (op != 3'b010) begin
      alu.zero = (alu.f == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_q     <= '0;
      last_gnt  <= 1'b1;
    end else if (|req_ready) begin
      rsp_valid <= 1'b1;
      rsp_id    <= sel;
      rsp_q     <= alu;
      last_gnt  <= sel;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_f    = rsp_q.f;
  assign rsp_zero = rsp_q.zero;
  assign rsp_over = rsp_q.over;
  assign rsp_cout = rsp_q.cout;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt [2];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst)
        cnt[i] <= '0;
      else if (req_ready[i] && cnt[i] != {CNT_W{1'b1}})
        cnt[i] <= cnt[i] + 1'b1;
    end
  end

  assign gnt_cnt = {cnt[1], cnt[0]};
`else
  assign gnt_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed self-checking bench for alu_rr_arbiter (W=4, CNT_W=2); counter checks follow ALU_ARB_STATS_EN.
module tb_alu_rr_arbiter;
  localparam int W  = 4;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*W-1:0]  req_a, req_b;
  logic [5:0]      req_op;
  logic            rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0]    rsp_f;
  logic            rsp_zero, rsp_over, rsp_cout;
  logic [2*CW-1:0] gnt_cnt;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic       id;
    logic [2:0] op;
    logic [3:0] a, b, f;
    logic       z, o, c;
  } vec_t;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.W(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_f(rsp_f), .rsp_zero(rsp_zero), .rsp_over(rsp_over), .rsp_cout(rsp_cout),
    .gnt_cnt(gnt_cnt)
  );

  // {valid, id, f, zero, over, cout}
  function automatic logic [8:0] rsp_vec();
    return {rsp_valid, rsp_id, rsp_f, rsp_zero, rsp_over, rsp_cout};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_ready = 1'b0;
    req_valid = 2'b01; req_a = 8'h43; req_b = 8'h21; req_op = 6'o00;
    tick(); tick();
    #1;
    n_total++;
    if (req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b exp 00", req_ready);
    else n_pass++;
    n_total++;
    if (rsp_vec() !== 9'b0) $display("FAIL reset_rsp: got %h exp 000", rsp_vec());
    else n_pass++;
    n_total++;
    if (gnt_cnt !== '0) $display("FAIL reset_gnt_cnt: got %h exp 0", gnt_cnt);
    else n_pass++;
    rst = 1'b0; req_valid = 2'b00;
    #1;
    n_total++;
    if (req_ready !== 2'b00) $display("FAIL idle_req_ready: got %b exp 00", req_ready);
    else n_pass++;
  endtask

  task automatic test_single();
    tick();
    req_valid = 2'b01; req_a = 8'hE3; req_b = 8'hD4; req_op = 6'o10; rsp_ready = 1'b1;
    #1;
    n_total++;
    if (req_ready !== 2'b01) $display("FAIL single_req_ready: got %b exp 01", req_ready);
    else n_pass++;
    tick();
    req_valid = 2'b00;
    n_total++;
    if (rsp_vec() !== {1'b1, 1'b0, 4'h7, 3'b000}) $display("FAIL single_rsp: got %h exp %h", rsp_vec(), {1'b1, 1'b0, 4'h7, 3'b000});
    else n_pass++;
    tick();
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL single_drain: got %b exp 0", rsp_valid);
    else n_pass++;
  endtask

  // Leaves a held result from requester 1 (2+3) for test_stall.
  task automatic test_round_robin();
    logic [8:0] exp_rsp;
    do_reset();
    req_valid = 2'b11; req_a = {4'h2, 4'h1}; req_b = {4'h3, 4'h1}; req_op = 6'o00; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_total++;
      if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10))
        $display("FAIL rr_grant[%0d]: got %b exp %b", k, req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      else n_pass++;
      tick();
      exp_rsp = (k % 2 == 0) ? {1'b1, 1'b0, 4'h2, 3'b000} : {1'b1, 1'b1, 4'h5, 3'b000};
      n_total++;
      if (rsp_vec() !== exp_rsp) $display("FAIL rr_rsp[%0d]: got %h exp %h", k, rsp_vec(), exp_rsp);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_total++;
      if (req_ready !== 2'b00) $display("FAIL stall_req_ready[%0d]: got %b exp 00", k, req_ready);
      else n_pass++;
      tick();
      n_total++;
      if (rsp_vec() !== {1'b1, 1'b1, 4'h5, 3'b000}) $display("FAIL stall_hold[%0d]: got %h exp %h", k, rsp_vec(), {1'b1, 1'b1, 4'h5, 3'b000});
      else n_pass++;
    end
    rsp_ready = 1'b1;
    #1;
    n_total++;
    if (req_ready !== 2'b01) $display("FAIL stall_resume: got %b exp 01", req_ready);
    else n_pass++;
    tick();
    req_valid = 2'b00;
    n_total++;
    if (rsp_vec() !== {1'b1, 1'b0, 4'h2, 3'b000}) $display("FAIL stall_after: got %h exp %h", rsp_vec(), {1'b1, 1'b0, 4'h2, 3'b000});
    else n_pass++;
    tick();
  endtask

  task automatic test_ops();
    vec_t tbl [11];
    int id;
    tbl[0]  = '{1'b0, 3'b000, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 3'b001, 4'h4, 4'h4, 4'h0, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 3'b110, 4'h8, 4'h1, 4'h1, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 3'b111, 4'h5, 4'h5, 4'h1, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 3'b011, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 3'b100, 4'h5, 4'h2, 4'h7, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 3'b101, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 3'b010, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 3'b000, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 3'b001, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 3'b110, 4'h1, 4'h8, 4'h0, 1'b0, 1'b1, 1'b0};
    rsp_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      id = int'(tbl[k].id);
      req_a  = 8'($urandom);
      req_b  = 8'($urandom);
      req_op = 6'($urandom);
      req_a[id*W +: W] = tbl[k].a;
      req_b[id*W +: W] = tbl[k].b;
      req_op[id*3 +: 3] = tbl[k].op;
      req_valid = tbl[k].id ? 2'b10 : 2'b01;
      #1;
      n_total++;
      if (req_ready !== req_valid) $display("FAIL op_grant[%0d]: got %b exp %b", k, req_ready, req_valid);
      else n_pass++;
      tick();
      req_valid = 2'b00;
      n_total++;
      if (rsp_vec() !== {1'b1, tbl[k].id, tbl[k].f, tbl[k].z, tbl[k].o, tbl[k].c})
        $display("FAIL op_rsp[%0d]: got %h exp %h", k, rsp_vec(), {1'b1, tbl[k].id, tbl[k].f, tbl[k].z, tbl[k].o, tbl[k].c});
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_stats();
    logic [2*CW-1:0] exp_cnt;
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 2'b01; req_a = 8'h11; req_b = 8'h22; req_op = 6'o00;
    for (int k = 1; k <= 5; k++) begin
      tick();
`ifdef ALU_ARB_STATS_EN
      exp_cnt = {2'b00, (k > 3) ? 2'd3 : 2'(k)};
`else
      exp_cnt = '0;
`endif
      n_total++;
      if (gnt_cnt !== exp_cnt) $display("FAIL stats_cnt[%0d]: got %h exp %h", k, gnt_cnt, exp_cnt);
      else n_pass++;
    end
    rsp_ready = 1'b0;
    rst = 1'b1;
    #1;
    n_total++;
    if (req_ready !== 2'b00) $display("FAIL stats_rst_ready: got %b exp 00", req_ready);
    else n_pass++;
    tick();
    rst = 1'b0; req_valid = 2'b00;
    n_total++;
    if ({rsp_valid, gnt_cnt} !== '0) $display("FAIL stats_rst: got %h exp 0", {rsp_valid, gnt_cnt});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_ops();
    test_stats();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
